// File: rtl/sram_device_model.sv
// Cycle-based stand-in for a 256Kx16 asynchronous SRAM at the controller's pins:
// WE-controlled write commit, pipelined reads with byte lanes, and sticky protocol checks.
module sram_device_model #(
    parameter int AW       = 18,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    sram_addr,
    input  logic [15:0]      sram_dq_write,
    input  logic             sram_dq_en,
    input  logic             sram_ce_n,
    input  logic             sram_oe_n,
    input  logic             sram_we_n,
    input  logic [1:0]       sram_be_n,
    output logic [15:0]      sram_dq_read,
    output logic             sram_dq_drive,
    output logic             contention_err,
    output logic             write_err,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    logic [15:0] mem [2**AW];

    logic          wr_act;
    logic          rd_act;
    logic          pend;
    logic          pend_en;
    logic          pend_mis;
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] start_addr;
    logic [15:0]   pend_data;
    logic [1:0]    pend_be;
    logic          commit;
    logic          commit_ok;
    logic          prev_rd;
    logic [AW-1:0] prev_addr;
    logic          rd_start;
    logic [15:0]   merged;
    logic [15:0]   rd_word;
    logic [15:0]   rd_masked;

    logic [READ_LAT-1:0] pipe_vld;
    logic [15:0]         pipe_data [READ_LAT];

    // we_n low wins over oe_n, so a cycle with both low is a pure write.
    assign wr_act    = !sram_ce_n && !sram_we_n;
    assign rd_act    = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign commit    = pend && !wr_act;
    assign commit_ok = commit && pend_en;
    assign rd_start  = rd_act && (!prev_rd || (sram_addr != prev_addr));

    always_comb begin
        merged = mem[pend_addr];
        if (!pend_be[0]) merged[7:0]  = pend_data[7:0];
        if (!pend_be[1]) merged[15:8] = pend_data[15:8];
        // A read landing in the commit cycle must already see the new word.
        rd_word = mem[sram_addr];
        if (commit_ok && (sram_addr == pend_addr)) rd_word = merged;
        rd_masked = {sram_be_n[1] ? 8'h00 : rd_word[15:8],
                     sram_be_n[0] ? 8'h00 : rd_word[7:0]};
    end

    // Array is intentionally left out of reset: contents survive it.
    always_ff @(posedge clk) begin
        if (commit_ok) mem[pend_addr] <= merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend       <= 1'b0;
            pend_en    <= 1'b0;
            pend_mis   <= 1'b0;
            pend_addr  <= '0;
            start_addr <= '0;
            pend_data  <= '0;
            pend_be    <= 2'b11;
        end else if (wr_act) begin
            pend      <= 1'b1;
            pend_addr <= sram_addr;
            pend_data <= sram_dq_write;
            pend_be   <= sram_be_n;
            pend_en   <= sram_dq_en;
            if (!pend) begin
                start_addr <= sram_addr;
                pend_mis   <= 1'b0;
            end else if (sram_addr != start_addr) begin
                pend_mis <= 1'b1;
            end
        end else if (pend) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_err      <= 1'b0;
            contention_err <= 1'b0;
            wr_count       <= '0;
            rd_count       <= '0;
            prev_rd        <= 1'b0;
            prev_addr      <= '0;
        end else begin
            if (commit && (!pend_en || pend_mis)) write_err <= 1'b1;
            if (commit_ok) wr_count <= wr_count + CNT_W'(1);
            if (sram_dq_en && sram_dq_drive) contention_err <= 1'b1;
            if (rd_start) rd_count <= rd_count + CNT_W'(1);
            prev_rd   <= rd_act;
            prev_addr <= sram_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_data[i] <= '0;
        end else begin
            pipe_vld[0]  <= rd_act;
            pipe_data[0] <= rd_act ? rd_masked : 16'h0000;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign sram_dq_drive = pipe_vld[READ_LAT-1];
    assign sram_dq_read  = pipe_vld[READ_LAT-1] ? pipe_data[READ_LAT-1] : 16'h0000;

endmodule
